// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch run/stop/lap sequencer.
package stopwatch_pkg;

    localparam int unsigned DIGITS_DEF = 4;
    localparam int unsigned LAP_IDX_W  = 3;
    localparam int unsigned BCD_W_DEF  = 4 * DIGITS_DEF;

    localparam logic [BCD_W_DEF-1:0] BCD_ZERO = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LAP  = 2'd2,
        ST_STOP = 2'd3
    } sw_state_e;

    // True in the states where the counter chain advances.
    function automatic logic is_counting(input sw_state_e st);
        return (st == ST_RUN) || (st == ST_LAP);
    endfunction

endpackage

// File: rtl/lap_buffer.sv
// Lap time shift buffer: newest entry at index 0, oldest falls off the top.
module lap_buffer
    import stopwatch_pkg::*;
#(
    parameter int unsigned W         = BCD_W_DEF,
    parameter int unsigned LAP_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 ss_nreset,
    input  logic                 push,
    input  logic                 flush,
    input  logic [W-1:0]         din,
    input  logic [LAP_IDX_W-1:0] rd_idx,
    output logic [LAP_IDX_W-1:0] lap_cnt,
    output logic [W-1:0]         rd_data_c
);

    logic [W-1:0] mem [LAP_DEPTH];

    // Shift in a new lap at entry 0 on push.
    always_ff @(posedge clk or negedge ss_nreset) begin
        if (!ss_nreset) begin
            for (int i = 0; i < int'(LAP_DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[0] <= din;
            for (int i = 1; i < int'(LAP_DEPTH); i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    // Number of valid entries, saturating at the buffer depth; flush empties it.
    always_ff @(posedge clk or negedge ss_nreset) begin
        if (!ss_nreset) begin
            lap_cnt <= '0;
        end else if (flush) begin
            lap_cnt <= '0;
        end else if (push && (lap_cnt != LAP_IDX_W'(LAP_DEPTH))) begin
            lap_cnt <= lap_cnt + LAP_IDX_W'(1);
        end
    end

    // Combinational read port; out-of-range indices read as zero.
    always_comb begin
        rd_data_c = '0;
        for (int i = 0; i < int'(LAP_DEPTH); i++) begin
            if (rd_idx == LAP_IDX_W'(i)) begin
                rd_data_c = mem[i];
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/stop/lap/clear sequencer for the BCD stopwatch counter chain.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned DIGITS     = DIGITS_DEF,
    parameter int unsigned LAP_DEPTH  = 4,
    parameter int unsigned HOLD_TICKS = 300
) (
    input  logic                 clk,
    input  logic                 ss_nreset,
    input  logic                 tick,
    input  logic                 start_stop,
    input  logic                 lap,
    input  logic                 clear,
    input  logic                 ovf_in,
    input  logic [4*DIGITS-1:0]  count,
    output logic                 cnt_en,
    output logic                 cnt_clr,
    output logic [4*DIGITS-1:0]  disp,
    output logic                 disp_lap,
    output logic [2:0]           lap_num,
    output logic                 running,
    output logic                 ovf
);

    localparam int unsigned W      = 4 * DIGITS;
    localparam int unsigned HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    sw_state_e            state;
    logic [HOLD_W-1:0]    hold;
    logic [W-1:0]         lap_reg;
    logic [LAP_IDX_W-1:0] ptr;
    logic [LAP_IDX_W-1:0] lap_cnt;
    logic [LAP_IDX_W-1:0] rd_idx_c;
    logic [LAP_IDX_W-1:0] ptr_next_c;
    logic [W-1:0]         rd_data_c;
    logic                 push_c;
    logic                 ovf_hit_c;

    // Event decode: overflow only matters while counting; a capture needs lap to win priority.
    always_comb begin
        ovf_hit_c  = ovf_in && is_counting(state);
        push_c     = lap && !clear && !ovf_hit_c && !start_stop && is_counting(state);
        ptr_next_c = (ptr == lap_cnt) ? '0 : ptr + LAP_IDX_W'(1);
        rd_idx_c   = ptr - LAP_IDX_W'(1);
    end

    lap_buffer #(
        .W         (W),
        .LAP_DEPTH (LAP_DEPTH)
    ) u_lap_buffer (
        .clk       (clk),
        .ss_nreset (ss_nreset),
        .push      (push_c),
        .flush     (clear),
        .din       (count),
        .rd_idx    (rd_idx_c),
        .lap_cnt   (lap_cnt),
        .rd_data_c (rd_data_c)
    );

    // Sequencer state, hold timer, recall pointer and registered outputs.
    always_ff @(posedge clk or negedge ss_nreset) begin
        if (!ss_nreset) begin
            state    <= ST_IDLE;
            hold     <= '0;
            lap_reg  <= W'(BCD_ZERO);
            ptr      <= '0;
            ovf      <= 1'b0;
            cnt_en   <= 1'b0;
            cnt_clr  <= 1'b0;
            disp_lap <= 1'b0;
            lap_num  <= '0;
        end else begin
            cnt_clr <= 1'b0;
            if (clear) begin
                state    <= ST_IDLE;
                hold     <= '0;
                ptr      <= '0;
                ovf      <= 1'b0;
                cnt_en   <= 1'b0;
                cnt_clr  <= 1'b1;
                disp_lap <= 1'b0;
                lap_num  <= '0;
            end else if (ovf_hit_c) begin
                state    <= ST_STOP;
                ptr      <= '0;
                ovf      <= 1'b1;
                cnt_en   <= 1'b0;
                disp_lap <= 1'b0;
                lap_num  <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_stop) begin
                            state  <= ST_RUN;
                            cnt_en <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (start_stop) begin
                            state  <= ST_STOP;
                            cnt_en <= 1'b0;
                        end else if (lap) begin
                            state    <= ST_LAP;
                            lap_reg  <= count;
                            hold     <= '0;
                            disp_lap <= 1'b1;
                            lap_num  <= 3'd1;
                        end
                    end
                    ST_LAP: begin
                        if (start_stop) begin
                            state    <= ST_STOP;
                            cnt_en   <= 1'b0;
                            disp_lap <= 1'b0;
                            lap_num  <= '0;
                        end else if (lap) begin
                            lap_reg <= count;
                            hold    <= '0;
                        end else if (tick) begin
                            if (hold == HOLD_W'(HOLD_TICKS - 1)) begin
                                state    <= ST_RUN;
                                hold     <= '0;
                                disp_lap <= 1'b0;
                                lap_num  <= '0;
                            end else begin
                                hold <= hold + HOLD_W'(1);
                            end
                        end
                    end
                    ST_STOP: begin
                        if (start_stop) begin
                            // An overflowed count cannot be resumed, only cleared.
                            if (!ovf) begin
                                state    <= ST_RUN;
                                cnt_en   <= 1'b1;
                                ptr      <= '0;
                                disp_lap <= 1'b0;
                                lap_num  <= '0;
                            end
                        end else if (lap && (lap_cnt != '0)) begin
                            ptr      <= ptr_next_c;
                            disp_lap <= (ptr_next_c != '0);
                            lap_num  <= ptr_next_c;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Display source select driven only by registered state.
    always_comb begin
        disp = count;
        if (state == ST_LAP) begin
            disp = lap_reg;
        end else if ((state == ST_STOP) && (ptr != '0)) begin
            disp = rd_data_c;
        end
    end

    assign running = cnt_en;

endmodule
